// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two result producers, the arbiter and the
// register-file write port.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_vld;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_rdy;

  logic              req1_vld;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_rdy;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Producers and the register file sit on the master side.
  modport master (
    output req0_vld, req0_addr, req0_data,
    output req1_vld, req1_addr, req1_data,
    input  req0_rdy, req1_rdy,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req0_vld, req0_addr, req0_data,
    input  req1_vld, req1_addr, req1_data,
    output req0_rdy, req1_rdy,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the 32-entry register file, with a
// pending-write scoreboard that stalls issue on in-flight source operands.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus,
  input  logic                  iss_vld,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic [ADDR_W-1:0]     chk_rs,
  input  logic [ADDR_W-1:0]     chk_rt,
  output logic                  stall,
  output logic [ADDR_W:0]       pend_cnt,
  output logic                  sb_err
);

  localparam int NREG = 1 << ADDR_W;

  logic              rr_last;   // 1: req1 won the last handshake
  logic [NREG-1:0]   sb_q;
  logic [NREG-1:0]   sb_d;
  logic              err_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              gnt0;
  logic              gnt1;
  logic              hs;
  logic [ADDR_W-1:0] hs_addr;
  logic [DATA_W-1:0] hs_data;
  logic              clr;
  logic              set;
  logic              haz_rs;
  logic              haz_rt;

  // Grants look only at valids and rr_last; gated so rdy is low in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      gnt0 = bus.req0_vld & (~bus.req1_vld | rr_last);
      gnt1 = bus.req1_vld & (~bus.req0_vld | ~rr_last);
    end
  end

  assign bus.req0_rdy = gnt0;
  assign bus.req1_rdy = gnt1;
  assign hs      = gnt0 | gnt1;
  assign hs_addr = gnt0 ? bus.req0_addr : bus.req1_addr;
  assign hs_data = gnt0 ? bus.req0_data : bus.req1_data;

  // NOTE: every variable gets its default before any branch, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    sb_d  = sb_q;
    err_d = sb_err;
    clr   = hs && (hs_addr != '0);
    set   = iss_vld && (iss_rd != '0);
    if (clr) begin
      if (!sb_q[hs_addr]) err_d = 1'b1;
      sb_d[hs_addr] = 1'b0;
    end
    // Applied after the clear so a same-cycle set of the same bit wins.
    if (set) begin
      if (sb_q[iss_rd] && !(clr && (hs_addr == iss_rd))) err_d = 1'b1;
      sb_d[iss_rd] = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last   <= 1'b1;
      // NOTE: the scoreboard is a flop array feeding stall, not a RAM, so
      // it must be cleared by reset like any other control state.
      sb_q      <= '0;
      sb_err    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      sb_q   <= sb_d;
      sb_err <= err_d;
      if (hs) begin
        rr_last   <= gnt1;
        wr_en_q   <= (hs_addr != '0);
        wr_addr_q <= hs_addr;
        wr_data_q <= hs_data;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  // The write landing this edge is also a hazard: the file's synchronous
  // read would still return the old value.
  always_comb begin
    haz_rs = (chk_rs != '0) && (sb_q[chk_rs] || (wr_en_q && (wr_addr_q == chk_rs)));
    haz_rt = (chk_rt != '0) && (sb_q[chk_rt] || (wr_en_q && (wr_addr_q == chk_rt)));
    stall  = haz_rs | haz_rt;
  end

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt = pend_cnt + (ADDR_W+1)'(sb_q[i]);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, compared against a register-level reference model.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       iss_vld;
  logic [4:0] iss_rd;
  logic [4:0] chk_rs;
  logic [4:0] chk_rt;
  logic       stall;
  logic [5:0] pend_cnt;
  logic       sb_err;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) ifc ();

  regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (ifc.slave),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .chk_rs   (chk_rs),
    .chk_rt   (chk_rt),
    .stall    (stall),
    .pend_cnt (pend_cnt),
    .sb_err   (sb_err)
  );

  typedef struct {
    int unsigned due;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_total = 0;
  int          n_bad   = 0;
  int unsigned cyc     = 0;

  // Reference model: which registers are awaiting a result, who gets the
  // next tie, and which register is being written this cycle (-1 = none).
  bit pend[32];
  bit m_err;
  int prefer;
  int cur_wr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(pend[r]);
    return n;
  endfunction

  function automatic bit m_haz(input logic [4:0] r);
    return (r != 5'd0) && (pend[r] || (cur_wr == int'(r)));
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    m_err  = 1'b0;
    prefer = 0;
    cur_wr = -1;
  endfunction

  task automatic idle_inputs();
    ifc.req0_vld = 1'b0; ifc.req0_addr = '0; ifc.req0_data = '0;
    ifc.req1_vld = 1'b0; ifc.req1_addr = '0; ifc.req1_data = '0;
    iss_vld = 1'b0; iss_rd = '0; chk_rs = '0; chk_rt = '0;
  endtask

  // Asynchronous reset from mid-cycle; outputs must clear without a clock.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_wr_en",    ifc.wr_en,    0);
    check("rst_pend_cnt", pend_cnt,     0);
    check("rst_sb_err",   sb_err,       0);
    check("rst_stall",    stall,        0);
    check("rst_rdy0",     ifc.req0_rdy, 0);
    check("rst_rdy1",     ifc.req1_rdy, 0);
    m_reset();
    exp_q.delete();
    idle_inputs();
    repeat (2) @(posedge clk);
    #6 rst = 1'b0;
  endtask

  // One cycle: drive, check the combinational outputs, then advance the
  // model across the coming edge and queue any register-file write.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] rs, input logic [4:0] rt,
                      output bit g0, output bit g1);
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          cleared;
    @(posedge clk);
    #1;
    ifc.req0_vld = v0; ifc.req0_addr = a0; ifc.req0_data = d0;
    ifc.req1_vld = v1; ifc.req1_addr = a1; ifc.req1_data = d1;
    iss_vld = iv; iss_rd = ird; chk_rs = rs; chk_rt = rt;
    #3;
    g0 = v0 && (!v1 || prefer == 0);
    g1 = v1 && (!v0 || prefer == 1);
    check("rdy0",     ifc.req0_rdy, g0);
    check("rdy1",     ifc.req1_rdy, g1);
    check("stall",    stall,        m_haz(rs) || m_haz(rt));
    check("pend_cnt", pend_cnt,     m_count());
    check("sb_err",   sb_err,       m_err);

    wa = g0 ? a0 : a1;
    wd = g0 ? d0 : d1;
    cleared = (g0 || g1) && (wa != 5'd0);
    cur_wr  = cleared ? int'(wa) : -1;
    if (cleared) begin
      exp_q.push_back('{due: cyc + 1, addr: wa, data: wd});
      if (!pend[wa]) m_err = 1'b1;
    end
    if (iv && ird != 5'd0 && pend[ird] && !(cleared && wa == ird)) m_err = 1'b1;
    if (cleared) pend[wa] = 1'b0;
    if (iv && ird != 5'd0) pend[ird] = 1'b1;
    if (g0) prefer = 1;
    if (g1) prefer = 0;
  endtask

  task automatic idle_step(input logic [4:0] rs);
    bit g0, g1;
    step(0, 0, 0, 0, 0, 0, 0, 0, rs, 0, g0, g1);
  endtask

  task automatic issue(input logic [4:0] rd);
    bit g0, g1;
    step(0, 0, 0, 0, 0, 0, 1, rd, 0, 0, g0, g1);
  endtask

  // Monitor: every write presented on the register-file port is matched
  // against the oldest queued expectation, including when it was due.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (ifc.wr_en === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("wr_unexpected_en", ifc.wr_en, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_cycle", cyc, e.due);
            check("wr_addr", ifc.wr_addr, e.addr);
            check("wr_data", ifc.wr_data, e.data);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          check("wr_missing_en", ifc.wr_en, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic logic [4:0] pick_reg(input bit want_pending);
    int s = int'($urandom_range(0, 31));
    for (int k = 0; k < 32; k++) begin
      int r = (s + k) % 32;
      if (r != 0 && pend[r] == want_pending) return 5'(r);
    end
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    bit g0, g1;
    bit         r0v, r1v;
    logic [4:0] r0a, r1a;
    logic [31:0] r0d, r1d;

    m_reset();
    idle_inputs();
    #2;
    ifc.req0_vld = 1'b1;
    ifc.req1_vld = 1'b1;
    apply_reset();

    // First write after reset: accepted at once, lands one cycle later.
    step(1, 5'd5, 32'hAAAA0001, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    idle_step(0);
    idle_step(0);
    apply_reset();

    // Both held valid: grants alternate starting with req0.
    for (int i = 0; i < 4; i++) begin
      step(1, 5'd3, 32'h3333_0003, 1, 5'd4, 32'h4444_0004, 0, 0, 0, 0, g0, g1);
      check("alt_rdy0", ifc.req0_rdy, 32'(i % 2 == 0));
    end
    idle_step(0);
    idle_step(0);
    apply_reset();

    // Operand in flight stalls through the register-file write cycle.
    issue(5'd7);
    idle_step(5'd7);
    check("raw_stall", stall, 1);
    step(0, 0, 0, 1, 5'd7, 32'h0BAD_F00D, 0, 0, 5'd7, 0, g0, g1);
    idle_step(5'd7);
    check("wr_cycle_stall", stall, 1);
    idle_step(5'd7);
    check("post_wr_stall", stall, 0);

    // Register 0: accepted, never written, never stalls.
    step(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 0, 0, g0, g1);
    idle_step(5'd0);
    idle_step(5'd0);
    apply_reset();

    // New producer on the same edge as the old one retires.
    issue(5'd9);
    step(1, 5'd9, 32'h0000_0909, 0, 0, 0, 1, 5'd9, 0, 0, g0, g1);
    issue(5'd9);
    check("same_edge_err", sb_err, 0);
    check("same_edge_cnt", pend_cnt, 1);
    idle_step(0);
    idle_step(0);
    check("sticky_err", sb_err, 1);
    apply_reset();

    // Reset mid-stream with three pending registers and a write on the port.
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    issue(5'd13);
    step(1, 5'd13, 32'h1313_1313, 0, 0, 0, 1, 5'd10, 0, 0, g0, g1);
    idle_step(5'd10);
    check("pre_rst_wr_en", ifc.wr_en, 1);
    check("pre_rst_cnt", pend_cnt, 3);
    apply_reset();
    step(1, 5'd1, 32'h0101_0101, 1, 5'd2, 32'h0202_0202, 0, 0, 0, 0, g0, g1);
    check("post_rst_prio", ifc.req0_rdy, 1);
    step(0, 0, 0, 1, 5'd2, 32'h0202_0202, 0, 0, 0, 0, g0, g1);
    idle_step(0);
    apply_reset();

    // Random traffic; a refused request is held unchanged until accepted.
    r0v = 0; r1v = 0; r0a = 0; r1a = 0; r0d = 0; r1d = 0;
    for (int i = 0; i < 600; i++) begin
      logic [4:0] ird, rs, rt;
      bit iv;
      if (i == 300) apply_reset();
      if (!r0v && $urandom_range(0, 1) == 1) begin
        r0v = 1; r0a = pick_reg($urandom_range(0, 3) != 0); r0d = $urandom;
      end
      if (!r1v && $urandom_range(0, 2) == 0) begin
        r1v = 1; r1a = pick_reg($urandom_range(0, 3) != 0); r1d = $urandom;
      end
      iv  = ($urandom_range(0, 2) == 0);
      ird = pick_reg($urandom_range(0, 7) == 0);
      rs  = pick_reg($urandom_range(0, 1) == 1);
      rt  = 5'($urandom_range(0, 31));
      step(r0v, r0a, r0d, r1v, r1a, r1d, iv, ird, rs, rt, g0, g1);
      if (g0) r0v = 0;
      if (g1) r1v = 0;
    end

    repeat (3) idle_step(0);
    repeat (2) @(posedge clk);
    #4;
    check("wr_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-back controller for the 32x32 CPU register file. It arbitrates the single register-file write port between two producers: req0 (ALU result) and req1 (load/multi-cycle unit). Each producer uses a valid/ready handshake. The block also holds a 32-entry pending-write scoreboard and raises a stall to the issue stage when a source operand is still in flight. It sits between the execute/memory stages and the register file's din/writeEnable/rd inputs.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register index width (fixed 32 registers)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_vld  in  1  ALU write-back request valid
req0_addr  in  5  ALU destination register
req0_data  in  32  ALU result
req0_rdy  out  1  ALU request accepted this cycle
req1_vld  in  1  load/multi-cycle write-back request valid
req1_addr  in  5  load destination register
req1_data  in  32  load data
req1_rdy  out  1  load request accepted this cycle
iss_vld  in  1  issue stage dispatches an instruction that writes iss_rd
iss_rd  in  5  destination of the issued instruction
chk_rs  in  5  source register A of the instruction in issue
chk_rt  in  5  source register B of the instruction in issue
stall  out  1  issue must hold (operand not yet readable)
wr_en  out  1  to register file writeEnable
wr_addr  out  5  to register file rd
wr_data  out  32  to register file din
pend_cnt  out  6  number of pending registers (popcount of scoreboard)
sb_err  out  1  sticky scoreboard protocol error

Behaviour:
- Reset (async, immediate): wr_en=0, wr_addr=0, wr_data=0, scoreboard=0, sb_err=0, rr_last=1 (req0 has first priority). All in-flight transfers are discarded. Outputs are defined while rst=1: rdy=0, stall=0, pend_cnt=0.
- Arbitration (combinational, round-robin):
  - One valid requester: it is granted.
  - Both valid: the requester not equal to rr_last is granted.
  - rdy_i = grant_i. At most one rdy is high per cycle. rdy never depends on the other requester's data.
  - A handshake (vld&rdy) updates rr_last to the winner at the clock edge.
  - An idle cycle leaves rr_last unchanged.
- Write path (1-cycle latency):
  - The cycle after a handshake, wr_en=1 with the winner's addr and data registered.
  - With no handshake, the next cycle has wr_en=0. wr_addr and wr_data hold their last values.
  - Handshake with addr=0: accepted (rdy=1), but wr_en stays 0 next cycle. Register 0 is never written.
- Scoreboard (bit per register, updated at the clock edge):
  - Set bit iss_rd when iss_vld=1 and iss_rd!=0.
  - Clear bit addr on a handshake of either requester.
  - Set and clear of the same addr in the same cycle: bit ends at 1 (the new producer wins).
  - iss_vld to a register already pending and not being cleared that cycle: sb_err goes to 1 and stays there until reset. The bit stays 1.
  - Clear of a bit that is not pending: no change to the scoreboard, and sb_err goes to 1.
- Stall (combinational) = hazard(chk_rs) | hazard(chk_rt), where hazard(r) is:
  - r!=0 and scoreboard[r]=1, or
  - r!=0 and wr_en=1 and wr_addr==r. This covers the register file's synchronous read sampling the old value in the same edge as the write.
  - Register 0 never stalls.
- pend_cnt: combinational popcount of the scoreboard, range 0..31.
- Requester contract: vld/addr/data stay stable while vld=1 and rdy=0. The block does not check this.

Test Plan:
- Reset release, req0_vld=1 addr=5 data=0xAAAA0001 → req0_rdy=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0xAAAA0001; the cycle after, wr_en=0.
- req0 and req1 held valid together for 4 cycles (addrs 3 and 4) → grants alternate req0, req1, req0, req1; wr_addr sequence 3, 4, 3, 4.
- iss_vld iss_rd=7, then chk_rs=7 → stall=1 and pend_cnt=1. req1 write to 7 → stall still 1 in the wr_en cycle (wr_addr=7), 0 the cycle after; pend_cnt=0.
- req0 handshake addr=0 data=0xFFFFFFFF → rdy=1, wr_en stays 0. chk_rs=0 with any state → stall=0.
- iss_vld iss_rd=9 in the same cycle as a req0 handshake addr=9 (bit 9 previously pending) → bit 9 remains 1, pend_cnt unchanged, sb_err=0. A second iss to 9 with no clear → sb_err=1 and it persists.
- Assert rst mid-stream with 3 pending registers and wr_en=1 → wr_en, pend_cnt, sb_err and stall go to 0 immediately. After release, req0 has priority when both requesters are valid.
